tdes_round_key_sequencer: RTL and testbench

- Iterative Triple-DES subkey source: accepts three 64-bit keys and issues all 48 round subkeys (3 passes x 16), one per valid/ready handshake, to the downstream iterative round engine.
- Computes PC-1, per-round C/D rotation and PC-2 internally, so no 16-wide parallel key table is needed.
- Supports EDE encrypt ordering and the reversed decrypt ordering, including per-pass direction reversal.

---
 rtl/tdes_round_key_sequencer.sv | 175 +++++++++++++++++
 tb/tb_tdes_round_key_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tdes_round_key_sequencer.sv
// tdes_round_key_sequencer
// Iterative Triple-DES subkey source. Captures three 64-bit keys on start and
// streams the 48 round subkeys (3 passes x 16 rounds) one per handshake. PC-1,
// the per-round C/D rotation and PC-2 are computed in place, so only the
// 56-bit C/D state is held rather than a table of subkeys.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start, decrypt    begin a sequence (sampled in IDLE only) / mode, captured with start
//   key1_64..key3_64  DES keys, bit 1 = MSB (DES numbering), parity bits ignored
//   subkey            current round subkey, PC-2 of the registered C/D
//   subkey_valid      subkey is valid
//   subkey_ready      consumer accepts subkey
//   pass_idx          current pass 0..2
//   round_idx         current round within the pass 0..15
//   busy              high whenever the sequencer is not idle
//   done              one-cycle pulse after the final handshake
//
// Handshake: a subkey transfers on a rising clk edge where subkey_valid and
// subkey_ready are both 1. While subkey_valid is 1 and no transfer happens,
// subkey, pass_idx and round_idx hold; subkey_valid never drops without a
// transfer.
module tdes_round_key_sequencer #(
  parameter int ROUNDS = 16,
  parameter int PASSES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        decrypt,
  input  logic [1:64] key1_64,
  input  logic [1:64] key2_64,
  input  logic [1:64] key3_64,
  output logic [1:48] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [1:0]  pass_idx,
  output logic [3:0]  round_idx,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);
  localparam logic [1:0] LAST_PASS  = 2'(PASSES - 1);

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t      state;
  logic [1:64] k1_q, k2_q, k3_q;
  logic        dec_q;
  logic [1:56] cd_q;

  logic [1:64] pass_key;
  logic        pass_rev;
  logic [4:0]  shift_idx;
  logic        shift_two;
  logic        hs;

  function automatic logic [1:56] pc1(input logic [1:64] k);
    logic [1:56] r;
    for (int i = 0; i < 56; i++) r[i+1] = k[PC1_T[i]];
    return r;
  endfunction

  function automatic logic [1:28] rot28(input logic [1:28] h, input logic left, input logic two);
    logic [1:28] r;
    if (left) r = two ? {h[3:28], h[1:2]} : {h[2:28], h[1]};
    else      r = two ? {h[27:28], h[1:26]} : {h[28], h[1:27]};
    return r;
  endfunction

  function automatic logic [1:56] rot_cd(input logic [1:56] cd, input logic left, input logic two);
    return {rot28(cd[1:28], left, two), rot28(cd[29:56], left, two)};
  endfunction

  // Pass ordering. Encrypt: k1 fwd, k2 rev, k3 fwd. Decrypt: k3 rev, k2 fwd,
  // k1 rev. The middle pass always runs opposite to the outer passes.
  always_comb begin
    pass_rev = (pass_idx == 2'd1) ^ dec_q;
    case (pass_idx)
      2'd0:    pass_key = dec_q ? k3_q : k1_q;
      2'd1:    pass_key = k2_q;
      default: pass_key = dec_q ? k1_q : k3_q;
    endcase
  end

  // Shift needed to reach the next round r = round_idx+2 (1-based). Forward
  // uses s[r]; reverse undoes the shift that produced the current round,
  // s[18-r] = s[16-round_idx]. s is 1 at rounds 1, 2, 9, 16 and 2 elsewhere.
  always_comb begin
    shift_idx = pass_rev ? (5'd16 - {1'b0, round_idx}) : ({1'b0, round_idx} + 5'd2);
    shift_two = !(shift_idx == 5'd1 || shift_idx == 5'd2 ||
                  shift_idx == 5'd9 || shift_idx == 5'd16);
  end

  always_comb begin
    subkey = '0;
    for (int i = 0; i < 48; i++) subkey[i+1] = cd_q[PC2_T[i]];
  end

  assign hs   = subkey_valid & subkey_ready;
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      k1_q         <= '0;
      k2_q         <= '0;
      k3_q         <= '0;
      dec_q        <= 1'b0;
      cd_q         <= '0;
      subkey_valid <= 1'b0;
      pass_idx     <= '0;
      round_idx    <= '0;
      done         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            k1_q      <= key1_64;
            k2_q      <= key2_64;
            k3_q      <= key3_64;
            dec_q     <= decrypt;
            pass_idx  <= '0;
            round_idx <= '0;
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          // Reverse starts from unrotated C0/D0: 28 total shifts make it C16/D16.
          cd_q         <= pass_rev ? pc1(pass_key) : rot_cd(pc1(pass_key), 1'b1, 1'b0);
          round_idx    <= '0;
          subkey_valid <= 1'b1;
          state        <= S_RUN;
        end
        S_RUN: begin
          if (hs) begin
            if (round_idx != LAST_ROUND) begin
              round_idx <= round_idx + 4'd1;
              cd_q      <= rot_cd(cd_q, !pass_rev, shift_two);
            end else begin
              subkey_valid <= 1'b0;
              if (pass_idx != LAST_PASS) begin
                pass_idx <= pass_idx + 2'd1;
                state    <= S_LOAD;
              end else begin
                done  <= 1'b1;
                state <= S_DONE;
              end
            end
          end
        end
        default: begin
          done      <= 1'b0;
          pass_idx  <= '0;
          round_idx <= '0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdes_round_key_sequencer.sv
// Testbench for tdes_round_key_sequencer: reference key schedule computed by
// cumulative left rotation from C0/D0, an expected-subkey queue filled when
// start is driven and drained on each handshake, plus a table of published
// subkeys for the classic key 133457799BBCDFF1.
module tb_tdes_round_key_sequencer;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;

  // clock / reset
  logic        clk = 1'b0;
  logic        reset;
  logic        start, decrypt, subkey_ready;
  logic [63:0] key1_64, key2_64, key3_64;
  logic [47:0] subkey;
  logic        subkey_valid, busy, done;
  logic [1:0]  pass_idx;
  logic [3:0]  round_idx;

  always #5 clk = ~clk;

  tdes_round_key_sequencer #(.ROUNDS(16), .PASSES(3)) dut (
    .clk(clk), .reset(reset), .start(start), .decrypt(decrypt),
    .key1_64(key1_64), .key2_64(key2_64), .key3_64(key3_64),
    .subkey(subkey), .subkey_valid(subkey_valid), .subkey_ready(subkey_ready),
    .pass_idx(pass_idx), .round_idx(round_idx), .busy(busy), .done(done));

  // scoreboard state
  logic [53:0] exp_q[$];
  logic [47:0] got_cur [48];
  logic [47:0] got_enc [48];
  logic [47:0] got_dec [48];
  int          hs_edge [48];
  int          checks = 0;
  int          errors = 0;
  int          edge_cnt, n_got, done_cnt, done_edge;
  logic        prev_done;
  bit          fin;

  typedef struct {
    logic        dec;
    int          idx;
    logic [47:0] exp;
  } vec_t;
  vec_t vecs [12];

  // reference model: Kn from scratch, total rotation = sum of s[1..n]
  function automatic logic [47:0] des_subkey(input logic [63:0] key, input int n);
    logic [27:0] c, d;
    logic [55:0] cd;
    logic [47:0] k;
    int          tot;
    for (int i = 0; i < 28; i++) begin
      c[27-i] = key[64-PC1_T[i]];
      d[27-i] = key[64-PC1_T[i+28]];
    end
    tot = 0;
    for (int j = 0; j < n; j++) tot += SHIFTS[j];
    tot = tot % 28;
    if (tot != 0) begin
      c = (c << tot) | (c >> (28 - tot));
      d = (d << tot) | (d >> (28 - tot));
    end
    cd = {c, d};
    for (int i = 0; i < 48; i++) k[47-i] = cd[56-PC2_T[i]];
    return k;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic push_expected(input logic [63:0] a, b, c, input logic dec);
    logic [63:0] key;
    logic        rev;
    for (int p = 0; p < 3; p++) begin
      rev = (p == 1) ^ dec;
      key = (p == 1) ? b : (((p == 0) ^ dec) ? a : c);
      for (int r = 0; r < 16; r++)
        exp_q.push_back({2'(p), 4'(r), des_subkey(key, rev ? 16 - r : r + 1)});
    end
  endtask

  // one clock: monitor at negedge, then cross the active edge
  task automatic cycle();
    logic [53:0] e;
    @(negedge clk);
    if (subkey_valid && subkey_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stream_extra got=%h exp=none", subkey);
      end else begin
        e = exp_q.pop_front();
        chk("stream", {10'd0, pass_idx, round_idx, subkey}, {10'd0, e});
        if (n_got < 48) begin
          got_cur[n_got] = subkey;
          hs_edge[n_got] = edge_cnt;
        end
        n_got++;
      end
    end
    if (prev_done) begin
      chk("busy_after_done", {63'd0, busy}, 64'd0);
      fin = 1'b1;
    end
    if (done) begin
      done_cnt++;
      done_edge = edge_cnt;
      chk("busy_during_done", {63'd0, busy}, 64'd1);
    end
    prev_done = done;
    @(posedge clk);
    #1;
    edge_cnt++;
  endtask

  // mode 0: ready=1; 1: backpressure at pass1 round3; 2: random ready with
  // start re-pulse and key changes; 3: reset at pass1 round7
  task automatic run_seq(input logic [63:0] a, b, c, input logic dec, input int mode);
    int guard;
    bit stalled;
    key1_64 = a; key2_64 = b; key3_64 = c; decrypt = dec;
    start = 1'b1; subkey_ready = 1'b1;
    push_expected(a, b, c, dec);
    n_got = 0; done_cnt = 0; done_edge = -1; prev_done = 1'b0; fin = 1'b0;
    edge_cnt = -1; stalled = 1'b0;
    cycle();
    start = 1'b0;
    guard = 0;
    while (!fin && guard < 800) begin
      if (mode == 1 && !stalled && pass_idx == 2'd1 && round_idx == 4'd3 && subkey_valid) begin
        stalled = 1'b1;
        subkey_ready = 1'b0;
        repeat (5) begin
          cycle();
          chk("stall_valid", {63'd0, subkey_valid}, 64'd1);
          chk("stall_round", {60'd0, round_idx}, 64'd3);
          chk("stall_pass", {62'd0, pass_idx}, 64'd1);
          chk("stall_subkey", {16'd0, subkey}, (exp_q.size() > 0) ? {16'd0, exp_q[0][47:0]} : 64'd0);
        end
        subkey_ready = 1'b1;
      end
      if (mode == 2) begin
        subkey_ready = 1'($urandom_range(0, 1));
        start = (guard == 20);
        if (guard == 20) begin
          key1_64 = {$urandom(), $urandom()};
          key2_64 = {$urandom(), $urandom()};
          key3_64 = {$urandom(), $urandom()};
          decrypt = ~dec;
        end
      end
      if (mode == 3 && pass_idx == 2'd1 && round_idx == 4'd7 && subkey_valid) begin
        #2;
        reset = 1'b1;
        #1;
        chk("abort_outputs",
            {8'd0, subkey, subkey_valid, pass_idx, round_idx, busy, done}, 64'd0);
        exp_q.delete();
        break;
      end
      cycle();
      guard++;
    end
    start = 1'b0;
    subkey_ready = 1'b1;
    if (mode != 3) begin
      if (!fin) begin
        checks++;
        errors++;
        $display("FAIL timeout got=%0d handshakes exp=48", n_got);
      end
      chk("done_count", 64'(done_cnt), 64'd1);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      if (mode == 0) begin
        chk("first_valid_edge", 64'(hs_edge[0]), 64'd1);
        chk("bubble_pass0", 64'(hs_edge[16] - hs_edge[15]), 64'd2);
        chk("bubble_pass1", 64'(hs_edge[32] - hs_edge[31]), 64'd2);
        chk("done_edge", 64'(done_edge), 64'd51);
      end
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0,  1, 48'h1B02EFFC7072};
    vecs[1]  = '{1'b0,  2, 48'h79AED9DBC9E5};
    vecs[2]  = '{1'b0, 16, 48'hCB3D8B0E17F5};
    vecs[3]  = '{1'b0, 17, 48'hCB3D8B0E17F5};
    vecs[4]  = '{1'b0, 32, 48'h1B02EFFC7072};
    vecs[5]  = '{1'b0, 33, 48'h1B02EFFC7072};
    vecs[6]  = '{1'b0, 48, 48'hCB3D8B0E17F5};
    vecs[7]  = '{1'b1,  1, 48'hCB3D8B0E17F5};
    vecs[8]  = '{1'b1, 15, 48'h79AED9DBC9E5};
    vecs[9]  = '{1'b1, 17, 48'h1B02EFFC7072};
    vecs[10] = '{1'b1, 32, 48'hCB3D8B0E17F5};
    vecs[11] = '{1'b1, 48, 48'h1B02EFFC7072};

    reset = 1'b1; start = 1'b0; decrypt = 1'b0; subkey_ready = 1'b1;
    key1_64 = '0; key2_64 = '0; key3_64 = '0;
    n_got = 0; done_cnt = 0; done_edge = -1; prev_done = 1'b0; fin = 1'b0; edge_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) begin
      cycle();
      chk("idle_outputs",
          {8'd0, subkey, subkey_valid, pass_idx, round_idx, busy, done}, 64'd0);
    end
    chk("idle_no_done", 64'(done_cnt), 64'd0);

    run_seq(KEY_A, KEY_A, KEY_A, 1'b0, 0);
    got_enc = got_cur;
    run_seq(KEY_A, KEY_A, KEY_A, 1'b1, 0);
    got_dec = got_cur;
    for (int i = 0; i < 12; i++)
      chk($sformatf("vec%0d_%s_k%0d", i, vecs[i].dec ? "dec" : "enc", vecs[i].idx),
          {16'd0, vecs[i].dec ? got_dec[vecs[i].idx-1] : got_enc[vecs[i].idx-1]},
          {16'd0, vecs[i].exp});

    run_seq({$urandom(), $urandom()}, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b0, 1);
    run_seq({$urandom(), $urandom()}, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b1, 2);

    run_seq(KEY_A, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b0, 3);
    done_cnt = 0;
    prev_done = 1'b0;
    repeat (3) cycle();
    chk("reset_hold_outputs",
        {8'd0, subkey, subkey_valid, pass_idx, round_idx, busy, done}, 64'd0);
    reset = 1'b0;
    repeat (2) cycle();
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    chk("abort_idle", {63'd0, busy}, 64'd0);

    run_seq({$urandom(), $urandom()}, {$urandom(), $urandom()}, 64'h0123456789ABCDEF, 1'b1, 0);
    chk("fresh_first_k16", {16'd0, got_cur[0]}, {16'd0, des_subkey(64'h0123456789ABCDEF, 16)});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
